wbu_tx_arb: RTL and testbench

WBU_TX_ARB -- requirements
Module: wbu_tx_arb

---
 rtl/wbu_pkg.sv | 18 +
 rtl/wbu_tx_arb_if.sv | 18 +
 rtl/wbu_tx_arb.sv | 132 +++++++++++++
 tb/tb_wbu_tx_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_pkg.sv
// Shared codeword constants and arbiter state encoding
// for the debug-bus transmit path.
package wbu_pkg;

  localparam logic [6:0] NL_CODE   = 7'h40;
  localparam logic [6:0] INT_CODE  = 7'h3E;
  localparam logic [6:0] IDLE_CODE = 7'h3F;

  typedef enum logic [2:0] {
    IDLE,
    PKT,
    NL,
    INT,
    INTNL,
    KEEP
  } state_t;

endpackage

// File: rtl/wbu_tx_arb_if.sv
// Codeword valid/busy handshake bundle used between the
// response source, the arbiter and the character encoder.
interface wbu_tx_arb_if;
  logic       stb;
  logic [6:0] bits;
  logic       last;
  logic       busy;

  modport master (
    output stb, bits, last,
    input  busy
  );

  modport slave (
    input  stb, bits, last,
    output busy
  );
endinterface

// File: rtl/wbu_tx_arb.sv
// Merges response packets, interrupt notices and keep-alive
// words into one codeword stream toward the encoder.
module wbu_tx_arb
  import wbu_pkg::*;
#(
  parameter int LGIDLE = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stb,
  input  logic [6:0] i_bits,
  input  logic       i_last,
  output logic       o_busy,
  input  logic       i_int,
  output logic       o_stb,
  output logic [6:0] o_bits,
  input  logic       i_busy
);

  state_t            state_q, state_d;
  logic              stb_q, stb_d;
  logic [6:0]        bits_q, bits_d;
  logic              pend_q, pend_d;
  logic              nl_q, nl_d;
  logic [LGIDLE-1:0] idle_q, idle_d;

  logic int_now;
  logic accept;
  logic xfer;
  logic open_st;

  assign int_now = pend_q | i_int;
  assign open_st = (state_q == IDLE) | (state_q == PKT);
  // A pending interrupt in IDLE wins over the source, so stall it
  assign o_busy  = stb_q | ~open_st
                 | ((state_q == IDLE) & int_now);
  assign accept  = i_stb & ~o_busy;
  assign xfer    = stb_q & ~i_busy;
  assign o_stb   = stb_q;
  assign o_bits  = bits_q;

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    bits_d  = bits_q;
    nl_d    = nl_q;
    idle_d  = idle_q;
    pend_d  = i_int
            | (pend_q & ~((state_q == INT) & xfer));

    if (xfer | accept)
      idle_d = '0;
    else if ((state_q == IDLE) & ~stb_q
             & ~int_now & ~(&idle_q))
      idle_d = idle_q + LGIDLE'(1);

    unique case (state_q)
      IDLE: begin
        if (int_now) begin
          state_d = INT;
          stb_d   = 1'b1;
          bits_d  = INT_CODE;
        end else if (accept) begin
          state_d = i_last ? NL : PKT;
          stb_d   = 1'b1;
          bits_d  = i_bits;
          nl_d    = 1'b0;
        end else if (&idle_q) begin
          state_d = KEEP;
          stb_d   = 1'b1;
          bits_d  = IDLE_CODE;
        end
      end
      PKT: begin
        if (xfer)
          stb_d = 1'b0;
        if (accept) begin
          stb_d  = 1'b1;
          bits_d = i_bits;
          nl_d   = 1'b0;
          if (i_last)
            state_d = NL;
        end
      end
      NL: begin
        // nl_q marks that the trailing newline is now on o_bits
        if (xfer) begin
          if (nl_q) begin
            state_d = IDLE;
            stb_d   = 1'b0;
            nl_d    = 1'b0;
          end else begin
            bits_d = NL_CODE;
            nl_d   = 1'b1;
          end
        end
      end
      INT: begin
        if (xfer) begin
          state_d = INTNL;
          bits_d  = NL_CODE;
        end
      end
      INTNL, KEEP: begin
        if (xfer) begin
          state_d = IDLE;
          stb_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      bits_q  <= 7'h00;
      pend_q  <= 1'b0;
      nl_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      bits_q  <= bits_d;
      pend_q  <= pend_d;
      nl_q    <= nl_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_wbu_tx_arb.sv
// Bench for wbu_tx_arb: directed tables, corner sequences
// and random packets against an output-stream model.
module tb_wbu_tx_arb;
  import wbu_pkg::*;

  localparam int KLG = 4;

  logic clk = 1'b0;
  logic rst;
  logic krst;
  logic i_int;
  logic k_busy, k_stb;
  logic [6:0] k_bits;

  always #5 clk = ~clk;

  wbu_tx_arb_if src_if ();
  wbu_tx_arb_if enc_if ();

  wbu_tx_arb dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_stb  (src_if.stb),
    .i_bits (src_if.bits),
    .i_last (src_if.last),
    .o_busy (src_if.busy),
    .i_int  (i_int),
    .o_stb  (enc_if.stb),
    .o_bits (enc_if.bits),
    .i_busy (enc_if.busy)
  );

  wbu_tx_arb #(.LGIDLE(KLG)) kdut (
    .i_clk  (clk),
    .i_reset(krst),
    .i_stb  (1'b0),
    .i_bits (7'h00),
    .i_last (1'b0),
    .o_busy (k_busy),
    .i_int  (1'b0),
    .o_stb  (k_stb),
    .o_bits (k_bits),
    .i_busy (1'b0)
  );

  int nvec = 0;
  int nerr = 0;
  logic [6:0] exp_q[$];
  bit lenient = 0;
  bit at_bound = 1;
  bit int_nl = 0;
  int ints_seen = 0;
  int pulses = 0;
  bit busy_rand = 0;
  bit int_rand = 0;
  bit prev_hold = 0;
  logic [6:0] prev_bits;
  logic [6:0] e;

  typedef struct packed {
    logic       drive;
    logic [6:0] bits;
    logic       last;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Output monitor: every transfer is matched against the
  // expected stream; interrupt pairs may appear between packets.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_hold = 0;
      at_bound  = 1;
      int_nl    = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_stb", 32'(enc_if.stb), 32'(1));
        chk("hold_bits", 32'(enc_if.bits), 32'(prev_bits));
      end
      if (enc_if.stb && !enc_if.busy) begin
        if (int_nl) begin
          chk("int_newline", 32'(enc_if.bits), 32'(NL_CODE));
          int_nl = 0;
        end else if (lenient && at_bound
                     && enc_if.bits == INT_CODE) begin
          ints_seen++;
          int_nl = 1;
        end else if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected: got %h want none",
                   enc_if.bits);
        end else begin
          e = exp_q.pop_front();
          chk("stream", 32'(enc_if.bits), 32'(e));
          at_bound = (e == NL_CODE);
        end
      end
      prev_hold = enc_if.stb && enc_if.busy;
      prev_bits = enc_if.bits;
    end
  end

  always @(negedge clk)
    if (busy_rand)
      enc_if.busy = ($urandom_range(0, 2) == 0);

  always @(negedge clk)
    if (int_rand) begin
      i_int = ($urandom_range(0, 39) == 0);
      if (i_int)
        pulses++;
    end

  task automatic send_word(input logic [6:0] b,
                           input logic l);
    int n = 0;
    bit done = 0;
    src_if.stb  = 1'b1;
    src_if.bits = b;
    src_if.last = l;
    while (!done && n < 300) begin
      #1;
      if (!src_if.busy)
        done = 1;
      @(negedge clk);
      n++;
    end
    src_if.stb = 1'b0;
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: word %h not accepted", b);
    end
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d left want 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    krst = 1'b1;
    i_int = 1'b0;
    src_if.stb = 1'b0;
    src_if.bits = 7'h00;
    src_if.last = 1'b0;
    enc_if.busy = 1'b0;
    enc_if.last = 1'b0;

    tbl[0] = '{1'b1, 7'h05, 1'b0, 7'h05};
    tbl[1] = '{1'b1, 7'h23, 1'b0, 7'h23};
    tbl[2] = '{1'b1, 7'h3D, 1'b1, 7'h3D};
    tbl[3] = '{1'b0, 7'h00, 1'b0, NL_CODE};
    tbl[4] = '{1'b1, 7'h11, 1'b1, 7'h11};
    tbl[5] = '{1'b0, 7'h00, 1'b0, NL_CODE};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stb", 32'(enc_if.stb), 32'(0));
    chk("rst_bits", 32'(enc_if.bits), 32'(0));
    chk("rst_busy", 32'(src_if.busy), 32'(0));
    @(negedge clk);

    // Table: plain packet then a single-word packet
    for (int i = 0; i < 6; i++)
      exp_q.push_back(tbl[i].exp);
    for (int i = 0; i < 6; i++)
      if (tbl[i].drive)
        send_word(tbl[i].bits, tbl[i].last);
    wait_drain(200);
    #1;
    chk("busy_after_nl", 32'(src_if.busy), 32'(0));
    @(negedge clk);

    // Interrupt during a packet is deferred to its end
    exp_q = '{7'h01, 7'h02, 7'h03, 7'h04, NL_CODE,
              INT_CODE, NL_CODE};
    send_word(7'h01, 1'b0);
    i_int = 1'b1;
    send_word(7'h02, 1'b0);
    i_int = 1'b0;
    send_word(7'h03, 1'b0);
    send_word(7'h04, 1'b1);
    wait_drain(200);
    repeat (20) @(negedge clk);

    // Interrupt together with a new word in IDLE goes first
    exp_q = '{INT_CODE, NL_CODE, 7'h07, NL_CODE};
    i_int = 1'b1;
    src_if.stb = 1'b1;
    src_if.bits = 7'h07;
    src_if.last = 1'b1;
    #1;
    chk("busy_int_idle", 32'(src_if.busy), 32'(1));
    @(negedge clk);
    i_int = 1'b0;
    send_word(7'h07, 1'b1);
    wait_drain(200);

    // Long encoder stall mid-packet
    exp_q = '{7'h21, 7'h22, 7'h23, 7'h24, NL_CODE};
    send_word(7'h21, 1'b0);
    send_word(7'h22, 1'b0);
    enc_if.busy = 1'b1;
    fork
      begin
        send_word(7'h23, 1'b0);
        send_word(7'h24, 1'b1);
      end
      begin
        repeat (50) begin
          @(negedge clk);
          #1;
          chk("stall_busy", 32'(src_if.busy), 32'(1));
          chk("stall_stb", 32'(enc_if.stb), 32'(1));
        end
        chk("stall_left", 32'(exp_q.size()), 32'(4));
        enc_if.busy = 1'b0;
      end
    join
    wait_drain(200);

    // Reset mid-packet abandons it, then a fresh packet works
    enc_if.busy = 1'b1;
    send_word(7'h2A, 1'b0);
    #1;
    chk("pre_rst_stb", 32'(enc_if.stb), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enc_if.busy = 1'b0;
    #1;
    chk("post_rst_stb", 32'(enc_if.stb), 32'(0));
    chk("post_rst_bits", 32'(enc_if.bits), 32'(0));
    chk("post_rst_busy", 32'(src_if.busy), 32'(0));
    @(negedge clk);
    exp_q = '{7'h2B, NL_CODE};
    send_word(7'h2B, 1'b1);
    wait_drain(200);

    // Random packets, random stalls, random interrupts
    lenient = 1;
    busy_rand = 1;
    int_rand = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      logic [6:0] w[4];
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        w[k] = 7'($urandom_range(0, 61));
        exp_q.push_back(w[k]);
      end
      exp_q.push_back(NL_CODE);
      for (int k = 0; k < len; k++)
        send_word(w[k], k == len - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    int_rand = 0;
    busy_rand = 0;
    @(negedge clk);
    i_int = 1'b0;
    enc_if.busy = 1'b0;
    wait_drain(3000);
    repeat (30) @(negedge clk);
    chk("int_pair_open", 32'(int_nl), 32'(0));
    if (pulses > 0) begin
      chk("ints_min", 32'(ints_seen >= 1), 32'(1));
      chk("ints_max", 32'(ints_seen <= pulses), 32'(1));
    end
    lenient = 0;

    // Keep-alive: 2^KLG idle cycles then one emit cycle
    krst = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      int period;
      period = (1 << KLG) + 1;
      #2;
      chk("keep_xfer", 32'(k_stb), 32'((c % period) == 0));
      if (k_stb)
        chk("keep_code", 32'(k_bits), 32'(IDLE_CODE));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
